// File: rtl/serial_stream_arbiter_pkg.sv
// Shared definitions for serial_stream_arbiter: FSM state encoding,
// default geometry constants, requester indices and the round-robin
// pick helper used by rr_arbiter2.
package serial_stream_arbiter_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int DET_LAT_DEF = 2;
  localparam int CNT_W_DEF   = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Lone requester wins outright; on a tie the one that did not own the
  // previous frame wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last_owner);
    logic pick;
    if (r0 && !r1) begin
      pick = REQ0;
    end else if (r1 && !r0) begin
      pick = REQ1;
    end else begin
      pick = ~last_owner;
    end
    return pick;
  endfunction

endpackage

// File: rtl/serial_stream_arbiter_if.sv
// Requester/detector link bundle for serial_stream_arbiter.
// slave  : arbiter side.  master : requesters + sequence detector side.
// Optional MATCH_IRQ_EN adds irq_clr / irq.
interface serial_stream_arbiter_if #(
  parameter int DATA_W = serial_stream_arbiter_pkg::DATA_W_DEF,
  parameter int CNT_W  = serial_stream_arbiter_pkg::CNT_W_DEF
);
  logic              req0;
  logic [DATA_W-1:0] data0;
  logic              req1;
  logic [DATA_W-1:0] data1;
  logic              det_z;
  logic              gnt0;
  logic              gnt1;
  logic              w_out;
  logic              w_valid;
  logic              det_clr;
  logic              busy;
  logic              owner;
  logic              done;
  logic [CNT_W-1:0]  match_cnt0;
  logic [CNT_W-1:0]  match_cnt1;
`ifdef MATCH_IRQ_EN
  logic              irq_clr;
  logic              irq;

  modport slave (
    input  req0, data0, req1, data1, det_z, irq_clr,
    output gnt0, gnt1, w_out, w_valid, det_clr, busy, owner, done,
           match_cnt0, match_cnt1, irq
  );
  modport master (
    output req0, data0, req1, data1, det_z, irq_clr,
    input  gnt0, gnt1, w_out, w_valid, det_clr, busy, owner, done,
           match_cnt0, match_cnt1, irq
  );
`else
  modport slave (
    input  req0, data0, req1, data1, det_z,
    output gnt0, gnt1, w_out, w_valid, det_clr, busy, owner, done,
           match_cnt0, match_cnt1
  );
  modport master (
    output req0, data0, req1, data1, det_z,
    input  gnt0, gnt1, w_out, w_valid, det_clr, busy, owner, done,
           match_cnt0, match_cnt1
  );
`endif
endinterface

// File: rtl/serial_stream_arbiter_rr_arbiter2.sv
// Two-way round-robin pick. winner is combinational from the requests and
// the remembered last owner; last_owner advances only on grant_en.
// Reset leaves last_owner=1 so requester 0 takes the first tie.
module rr_arbiter2
  import serial_stream_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  output logic winner
);

  logic last_owner;

  // Combinational round-robin choice.
  always_comb begin
    winner = rr_pick(req0, req1, last_owner);
  end

  // Remember who was granted so the other side wins the next tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_owner <= REQ1;
    end else if (grant_en) begin
      last_owner <= winner;
    end
  end

endmodule

// File: rtl/serial_stream_arbiter.sv
// serial_stream_arbiter: shares one serial sequence detector between two
// frame requesters. Grants round-robin, shifts the winner's frame MSB-first,
// waits DET_LAT cycles for late z pulses, credits z pulses to the owner and
// clears the detector between frames.
// Optional feature macro: MATCH_IRQ_EN (irq_clr input, sticky irq output).
module serial_stream_arbiter
  import serial_stream_arbiter_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DET_LAT = DET_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  serial_stream_arbiter_if.slave  bus
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FL_W  = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(DET_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [FL_W-1:0]   flush_cnt;
  logic              grant_en;
  logic              winner;
  logic              z_count;
`ifdef MATCH_IRQ_EN
  logic              frame_hit;
`endif

  // Arbitration strobe: a grant is taken only from IDLE with a request up.
  always_comb begin
    grant_en = 1'b0;
    z_count  = 1'b0;
    if (state == IDLE) begin
      grant_en = bus.req0 | bus.req1;
    end else begin
      grant_en = 1'b0;
    end
    if ((state == SHIFT) || (state == FLUSH)) begin
      z_count = bus.det_z;
    end else begin
      z_count = 1'b0;
    end
  end

  rr_arbiter2 u_rr (
    .clock    (clock),
    .reset    (reset),
    .req0     (bus.req0),
    .req1     (bus.req1),
    .grant_en (grant_en),
    .winner   (winner)
  );

  // Frame sequencer with registered outputs and owner-attributed z counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      shreg          <= {DATA_W{1'b0}};
      bit_cnt        <= {BIT_W{1'b0}};
      flush_cnt      <= {FL_W{1'b0}};
      bus.gnt0       <= 1'b0;
      bus.gnt1       <= 1'b0;
      bus.w_out      <= 1'b0;
      bus.w_valid    <= 1'b0;
      bus.det_clr    <= 1'b1;
      bus.busy       <= 1'b0;
      bus.owner      <= REQ0;
      bus.done       <= 1'b0;
      bus.match_cnt0 <= {CNT_W{1'b0}};
      bus.match_cnt1 <= {CNT_W{1'b0}};
`ifdef MATCH_IRQ_EN
      frame_hit      <= 1'b0;
      bus.irq        <= 1'b0;
`endif
    end else begin
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.done    <= 1'b0;
      bus.det_clr <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_en) begin
            state     <= LOAD;
            bus.gnt0  <= (winner == REQ0);
            bus.gnt1  <= (winner == REQ1);
            bus.owner <= winner;
            bus.busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          // Winner's data is taken at the end of its grant cycle.
          if (bus.owner == REQ1) begin
            shreg     <= bus.data1;
            bus.w_out <= bus.data1[DATA_W-1];
          end else begin
            shreg     <= bus.data0;
            bus.w_out <= bus.data0[DATA_W-1];
          end
          bus.w_valid <= 1'b1;
          bit_cnt     <= {BIT_W{1'b0}};
          state       <= SHIFT;
        end
        SHIFT: begin
          shreg <= {shreg[DATA_W-2:0], 1'b0};
          if (bit_cnt == BIT_LAST) begin
            bus.w_valid <= 1'b0;
            bus.w_out   <= 1'b0;
            bit_cnt     <= {BIT_W{1'b0}};
            flush_cnt   <= {FL_W{1'b0}};
            state       <= FLUSH;
          end else begin
            bus.w_out <= shreg[DATA_W-2];
            bit_cnt   <= bit_cnt + BIT_W'(1);
            state     <= SHIFT;
          end
        end
        FLUSH: begin
          if (flush_cnt == FL_LAST) begin
            bus.done    <= 1'b1;
            bus.det_clr <= 1'b1;
            state       <= DONE;
          end else begin
            flush_cnt <= flush_cnt + FL_W'(1);
            state     <= FLUSH;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy    <= 1'b0;
          bus.w_valid <= 1'b0;
          bus.w_out   <= 1'b0;
          state       <= IDLE;
        end
      endcase

      // z pulses only count while this frame owns the detector.
      if (z_count) begin
        if (bus.owner == REQ1) begin
          if (bus.match_cnt1 != CNT_MAX) begin
            bus.match_cnt1 <= bus.match_cnt1 + CNT_ONE;
          end
        end else begin
          if (bus.match_cnt0 != CNT_MAX) begin
            bus.match_cnt0 <= bus.match_cnt0 + CNT_ONE;
          end
        end
      end

`ifdef MATCH_IRQ_EN
      // Per-frame hit flag feeds the sticky irq; set beats clear.
      if (state == LOAD) begin
        frame_hit <= 1'b0;
      end else if (z_count) begin
        frame_hit <= 1'b1;
      end
      if ((state == DONE) && frame_hit) begin
        bus.irq <= 1'b1;
      end else if (bus.irq_clr) begin
        bus.irq <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_serial_stream_arbiter.sv
// Directed testbench for serial_stream_arbiter. A second instance built with
// CNT_W=2 exercises counter saturation. irq checks are compiled only when
// MATCH_IRQ_EN is defined.
module tb_serial_stream_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  serial_stream_arbiter_if bus ();
  serial_stream_arbiter_if #(.CNT_W(2)) bus2 ();

  serial_stream_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  serial_stream_arbiter #(.CNT_W(2)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    bus.req0  = 1'b0; bus.req1  = 1'b0; bus.data0  = 8'h00; bus.data1  = 8'h00; bus.det_z  = 1'b0;
    bus2.req0 = 1'b0; bus2.req1 = 1'b0; bus2.data0 = 8'h00; bus2.data1 = 8'h00; bus2.det_z = 1'b0;
`ifdef MATCH_IRQ_EN
    bus.irq_clr = 1'b0; bus2.irq_clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  // Wait (bounded) for a grant on the main instance.
  task automatic wait_gnt(output int which, output int cycles);
    which  = -1;
    cycles = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (bus.gnt0 || bus.gnt1) begin
        which  = bus.gnt1 ? 1 : 0;
        cycles = i;
        break;
      end
    end
    if (which < 0) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  // Expect the 8 frame bits MSB-first, one per cycle, with w_valid high.
  task automatic check_bits(input string tag, input logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      step();
      chk($sformatf("%s_w_out_%0d", tag, 7 - i), bus.w_out, d[i]);
      chk($sformatf("%s_w_valid_%0d", tag, 7 - i), bus.w_valid, 1'b1);
    end
  endtask

  initial begin
    int w;
    int c;
    logic [15:0] pat;
    logic [15:0] pat2;

    // Reset state and det_clr release behaviour.
    reset = 1'b0;
    clear_inputs();
    repeat (2) step();
    chk("rst_outs", {bus.gnt0, bus.gnt1, bus.w_out, bus.w_valid, bus.busy, bus.done, bus.owner}, 7'd0);
    chk("rst_det_clr", bus.det_clr, 1'b1);
    chk("rst_cnt", {bus.match_cnt0, bus.match_cnt1}, 16'd0);
    reset = 1'b1;
    #1;
    chk("rel_det_clr_hi", bus.det_clr, 1'b1);
    step();
    chk("rel_det_clr_lo", bus.det_clr, 1'b0);

    // Single frame from requester 0, data 8'hB4.
    bus.data0 = 8'hB4;
    bus.req0  = 1'b1;
    wait_gnt(w, c);
    chk("f0_gnt_who", w, 32'd0);
    chk("f0_gnt_lat", c, 32'd1);
    chk("f0_busy", bus.busy, 1'b1);
    chk("f0_owner", bus.owner, 1'b0);
    bus.req0 = 1'b0;
    check_bits("f0", 8'hB4);
    step();
    chk("f0_flush", {bus.w_valid, bus.w_out, bus.done}, 3'd0);
    step();
    step();
    chk("f0_done", bus.done, 1'b1);
    chk("f0_done_clr", bus.det_clr, 1'b1);
    chk("f0_done_busy", bus.busy, 1'b1);
    step();
    chk("f0_after", {bus.done, bus.busy, bus.det_clr}, 3'd0);

    // Both requesters held from reset: alternate 0,1,0,1 at 13-cycle spacing.
    do_reset();
    bus.data0 = 8'h0F;
    bus.data1 = 8'hF0;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_gnt(w, c);
      chk($sformatf("rr_order_%0d", f), w, f % 2);
      chk($sformatf("rr_period_%0d", f), c, (f == 0) ? 32'd1 : 32'd13);
      chk($sformatf("rr_owner_%0d", f), bus.owner, f % 2);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      step();
    end
    chk("rr_idle", bus.busy, 1'b0);

    // z attribution (main) and saturation (CNT_W=2 instance) in parallel.
    do_reset();
    bus.det_z = 1'b1;
    step();
    step();
    bus.det_z = 1'b0;
    step();
    chk("z_idle_cnt", {bus.match_cnt0, bus.match_cnt1}, 16'd0);
    bus.data1  = 8'h5A;
    bus.req1   = 1'b1;
    bus2.data0 = 8'hFF;
    bus2.req0  = 1'b1;
    wait_gnt(w, c);
    chk("z_gnt_who", w, 32'd1);
    chk("sat_gnt0", bus2.gnt0, 1'b1);
    bus.req1  = 1'b0;
    bus2.req0 = 1'b0;
    // Main: LOAD(1), SHIFT(2,5), FLUSH(10), DONE(12) -> 3 counted.
    pat  = 16'h1426;
    // Saturating instance: 5 pulses in SHIFT (2..6).
    pat2 = 16'h007C;
    bus.det_z  = pat[1];
    bus2.det_z = pat2[1];
    for (int k = 2; k <= 13; k++) begin
      step();
      bus.det_z  = pat[k];
      bus2.det_z = pat2[k];
    end
    bus.det_z  = 1'b0;
    bus2.det_z = 1'b0;
    step();
    chk("z_cnt1", bus.match_cnt1, 8'd3);
    chk("z_cnt0", bus.match_cnt0, 8'd0);
    chk("z_owner", bus.owner, 1'b1);
    chk("sat_cnt0", bus2.match_cnt0, 2'd3);
    chk("sat_cnt1", bus2.match_cnt1, 2'd0);
`ifdef MATCH_IRQ_EN
    chk("irq_set", bus2.irq, 1'b1);
    chk("irq_set_main", bus.irq, 1'b1);
    bus2.irq_clr = 1'b1;
    step();
    bus2.irq_clr = 1'b0;
    chk("irq_clr", bus2.irq, 1'b0);
    chk("irq_main_held", bus.irq, 1'b1);
`endif

    // Reset during SHIFT bit 4 with req1 held, then full replay.
    do_reset();
    bus.data1 = 8'hC3;
    bus.req1  = 1'b1;
    wait_gnt(w, c);
    chk("ab_gnt_who", w, 32'd1);
    repeat (5) step();
    chk("ab_mid_valid", bus.w_valid, 1'b1);
    reset = 1'b0;
    #1;
    chk("ab_rst_outs", {bus.w_valid, bus.busy, bus.gnt1, bus.done}, 4'd0);
    chk("ab_rst_clr", bus.det_clr, 1'b1);
    step();
    step();
    chk("ab_no_done", bus.done, 1'b0);
    reset = 1'b1;
    wait_gnt(w, c);
    chk("ab_regnt_who", w, 32'd1);
    chk("ab_regnt_lat", c, 32'd1);
    bus.req1 = 1'b0;
    check_bits("ab", 8'hC3);
    repeat (3) step();
    chk("ab_done", bus.done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_stream_arbiter.md
Name: serial_stream_arbiter

Overview:
- Shares one serial sequence-detector datapath (input w, output z) between two frame requesters.
- Arbitrates round-robin and latches the winner's parallel frame.
- Shifts the frame out MSB-first on w_out, then waits for detector latency.
- Attributes detector z pulses to the owning requester, clears the detector between frames, and signals frame completion.

Parameters:
- DATA_W, 8, bits per frame shifted to detector.
- DET_LAT, 2, cycles held after last bit to collect late z pulses (>=1).
- CNT_W, 8, width of per-requester saturating match counters.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req0  in  1  requester 0 frame request; held until gnt0.
- data0  in  DATA_W  requester 0 frame; sampled in gnt0 cycle.
- req1  in  1  requester 1 frame request.
- data1  in  DATA_W  requester 1 frame.
- det_z  in  1  detector z output.
- gnt0  out  1  one-cycle grant/accept to requester 0.
- gnt1  out  1  one-cycle grant/accept to requester 1.
- w_out  out  1  serial bit to detector w.
- w_valid  out  1  w_out carries a frame bit.
- det_clr  out  1  active-high synchronous clear to detector reset.
- busy  out  1  frame in progress (state != IDLE).
- owner  out  1  requester owning current/last frame.
- done  out  1  one-cycle end-of-frame pulse.
- match_cnt0  out  CNT_W  z pulses attributed to requester 0.
- match_cnt1  out  CNT_W  z pulses attributed to requester 1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_owner=1 so requester 0 wins first tie.
  - gnt0=gnt1=w_out=w_valid=busy=done=0, owner=0, counters=0, shift register=0, bit counter=0.
  - det_clr=1 during reset and for the first cycle after release.
- All outputs are registered. Moore FSM with states IDLE, LOAD, SHIFT, FLUSH, DONE.
- IDLE:
  - Any req high at an edge -> LOAD.
  - Winner: the only requester asserting, else the requester != last_owner.
- LOAD, 1 cycle:
  - gnt of winner=1, owner=winner, last_owner=winner.
  - Shift register loads winner's data, bit counter=0. -> SHIFT.
- SHIFT, DATA_W cycles:
  - w_valid=1, w_out=shreg[DATA_W-1].
  - Shift left with zero fill and increment bit counter.
  - After bit DATA_W-1 -> FLUSH.
- FLUSH, DET_LAT cycles: w_valid=0, w_out=0. -> DONE.
- DONE, 1 cycle: done=1, det_clr=1. -> IDLE.
- Latency from req sampled in IDLE to done: 1+DATA_W+DET_LAT+1 cycles.
- Back-to-back: a req seen in IDLE the cycle after DONE is granted immediately; no idle gap beyond that one IDLE cycle.
- Match counting:
  - det_z sampled in SHIFT and FLUSH only; each cycle det_z=1 increments the owner's counter.
  - Counters saturate at 2^CNT_W-1. det_z ignored in IDLE, LOAD and DONE.
  - Counters are never cleared except by reset.
- Request dropped before grant: no effect; arbitration re-evaluated each IDLE cycle.
- req of the non-owner during a frame: held, served next.
- Reset mid-frame: frame aborted, no done, no gnt; pending req is re-granted after reset release per the reset-state tie rule.

Optional Feature:
- Macro MATCH_IRQ_EN.
- When defined:
  - Adds input irq_clr (1) and output irq (1).
  - irq sets in DONE if the frame produced >=1 counted z pulse, and stays set until irq_clr=1.
  - Set wins over simultaneous clear. irq reset value 0.
- When undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - state enum (IDLE=0, LOAD=1, SHIFT=2, FLUSH=3, DONE=4), 3-bit encoding.
  - default DATA_W/DET_LAT/CNT_W constants.
  - requester index localparams REQ0=0, REQ1=1.
- One natural sub-module: rr_arbiter2, a 2-way round-robin pick with a last_owner register and a grant-enable strobe.

Test Plan:
- Reset, then hold reset=0 mid-run -> all outputs at reset values and det_clr=1; the cycle after release det_clr=1, then 0.
- req0=1, data0=8'hB4 -> gnt0 one cycle later; w_out=1,0,1,1,0,1,0,0 with w_valid=1 for 8 cycles; done 12 cycles after req sample; det_clr=1 with done.
- req0=req1=1 from reset, held -> grants order 0,1,0,1; each frame 12 cycles; owner tracks grant.
- Frame from req1 with det_z pulsed 3 times in SHIFT/FLUSH plus 2 pulses in IDLE -> match_cnt1=3, match_cnt0=0.
- CNT_W=2, 5 z pulses in one req0 frame -> match_cnt0=3 (saturated); MATCH_IRQ_EN build: irq=1 after done, cleared by irq_clr.
- reset=0 during SHIFT bit 4 with req1 held -> no done, w_valid=0; after release req1 regranted, full 8 bits replayed.
